// File: rtl/bin_map_packer_if.sv
// +----------------------------------------------------------------------------+
// | bin_map_packer_if : decision-bit input and packed-word output handshake   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bin_map_packer_if #(
  parameter int OW = 16
);
  logic          iEN;
  logic          iDATA;
  logic          oVALID;
  logic          iREADY;
  logic [OW-1:0] oDATA;
  logic          oLAST;

  modport slave (
    input  iEN,
    input  iDATA,
    input  iREADY,
    output oVALID,
    output oDATA,
    output oLAST
  );

  modport master (
    output iEN,
    output iDATA,
    output iREADY,
    input  oVALID,
    input  oDATA,
    input  oLAST
  );
endinterface

`default_nettype wire

// File: rtl/bin_map_packer.sv
// +----------------------------------------------------------------------------+
// | bin_map_packer : packs per-bin threshold decisions into OW-bit words with  |
// | frame tagging and a show-ahead output FIFO. Rev 1.0                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module bin_map_packer #(
  parameter int OW         = 16,
  parameter int FRAME_BITS = 1024,
  parameter int DEPTH      = 4
) (
  input  wire logic         iCLK,
  input  wire logic         iRSTn,
  input  wire logic         iCLR,
  bin_map_packer_if.slave   bus,
  output logic              oFRAME_DONE,
  output logic              oOVF
);

  localparam int c_BW = (OW > 1) ? $clog2(OW) : 1;
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);

  localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(OW - 1);
  localparam logic [16:0]     c_FRM_LAST = 17'(FRAME_BITS - 1);
  localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);

  logic [OW-1:0]   r_asm;
  logic [c_BW-1:0] r_bit_cnt;
  logic [16:0]     r_frm_cnt;
  logic [OW-1:0]   r_mem_data [DEPTH];
  logic            r_mem_last [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic            r_frame_done;
  logic            r_ovf;

  logic            w_accept;
  logic            w_frm_end;
  logic            w_word_end;
  logic [OW-1:0]   w_word;
  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_accept   = bus.iEN && !iCLR;
  assign w_frm_end  = w_accept && (r_frm_cnt == c_FRM_LAST);
  // Word and frame limits hitting together still yield a single completion.
  assign w_word_end = w_accept && ((r_bit_cnt == c_BIT_LAST) || (r_frm_cnt == c_FRM_LAST));

  always_comb begin
    w_word            = r_asm;
    w_word[r_bit_cnt] = bus.iDATA;
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = w_valid && bus.iREADY && !iCLR;
  assign w_push  = w_word_end && (!w_full || w_pop);
  assign w_drop  = w_word_end && w_full && !w_pop;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_asm        <= '0;
      r_bit_cnt    <= '0;
      r_frm_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (iCLR) begin
      r_asm        <= '0;
      r_bit_cnt    <= '0;
      r_frm_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_frame_done <= w_frm_end;
      r_ovf        <= r_ovf | w_drop;
      if (w_accept) begin
        if (w_word_end) begin
          r_asm     <= '0;
          r_bit_cnt <= '0;
        end else begin
          r_asm     <= w_word;
          r_bit_cnt <= r_bit_cnt + c_BW'(1);
        end
        r_frm_cnt <= w_frm_end ? '0 : r_frm_cnt + 17'd1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (iCLR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_word;
      r_mem_last[r_wptr] <= w_frm_end;
    end
  end

  assign bus.oVALID = w_valid;
  assign bus.oDATA  = w_valid ? r_mem_data[r_rptr] : '0;
  assign bus.oLAST  = w_valid ? r_mem_last[r_rptr] : 1'b0;
  assign oFRAME_DONE = r_frame_done;
  assign oOVF        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bin_map_packer.sv
// +----------------------------------------------------------------------------+
// | tb_bin_map_packer : scoreboard bench for bin_map_packer (two frame sizes)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bin_map_packer;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr_a;
  logic clr_b;
  logic fd_a;
  logic fd_b;
  logic ovf_a;
  logic ovf_b;

  int n_checks;
  int n_errors;

  exp_t q_a[$];
  exp_t q_b[$];

  bin_map_packer_if #(.OW(16)) ba ();
  bin_map_packer_if #(.OW(16)) bb ();

  bin_map_packer #(.OW(16), .FRAME_BITS(1024), .DEPTH(4)) dut_a (
    .iCLK        (clk),
    .iRSTn       (rst_n),
    .iCLR        (clr_a),
    .bus         (ba.slave),
    .oFRAME_DONE (fd_a),
    .oOVF        (ovf_a)
  );

  bin_map_packer #(.OW(16), .FRAME_BITS(20), .DEPTH(4)) dut_b (
    .iCLK        (clk),
    .iRSTn       (rst_n),
    .iCLR        (clr_b),
    .bus         (bb.slave),
    .oFRAME_DONE (fd_b),
    .oOVF        (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: compare every accepted word against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && ba.oVALID && ba.iREADY) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_word actual=%h expected=none", ba.oDATA);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_word_data", {16'h0, ba.oDATA}, {16'h0, e.d});
        chk("a_word_last", {31'h0, ba.oLAST}, {31'h0, e.l});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bb.oVALID && bb.iREADY) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_word actual=%h expected=none", bb.oDATA);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_word_data", {16'h0, bb.oDATA}, {16'h0, e.d});
        chk("b_word_last", {31'h0, bb.oLAST}, {31'h0, e.l});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      ba.iEN   = 1'b1;
      ba.iDATA = pat[i];
      tick();
    end
    ba.iEN = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      bb.iEN   = 1'b1;
      bb.iDATA = pat[i];
      tick();
    end
    bb.iEN = 1'b0;
  endtask

  task automatic clear_a();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  task automatic drain_a();
    int k;
    k = 0;
    while (q_a.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("a_drain_left", q_a.size(), 0);
  endtask

  task automatic drain_b();
    int k;
    k = 0;
    while (q_b.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk("b_drain_left", q_b.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    clr_a     = 1'b0;
    clr_b     = 1'b0;
    ba.iEN    = 1'b0;
    ba.iDATA  = 1'b0;
    ba.iREADY = 1'b1;
    bb.iEN    = 1'b0;
    bb.iDATA  = 1'b0;
    bb.iREADY = 1'b1;

    repeat (3) tick();
    chk("rst_valid", {31'h0, ba.oVALID}, 0);
    chk("rst_data",  {16'h0, ba.oDATA}, 0);
    chk("rst_fd",    {31'h0, fd_a}, 0);
    chk("rst_ovf",   {31'h0, ovf_a}, 0);
    rst_n = 1'b1;
    tick();

    // Alternating pattern, first bit in bit 0.
    q_a.push_back('{d: 16'h5555, l: 1'b0});
    send_a(16'h5555, 15);
    chk("pk_valid_early", {31'h0, ba.oVALID}, 0);
    send_a(16'h0000, 1);
    chk("pk_valid", {31'h0, ba.oVALID}, 1);
    chk("pk_data",  {16'h0, ba.oDATA}, 32'h5555);
    chk("pk_last",  {31'h0, ba.oLAST}, 0);
    tick();
    chk("pk_idle_valid", {31'h0, ba.oVALID}, 0);
    chk("pk_idle_data",  {16'h0, ba.oDATA}, 0);

    // Clear wins over a same-cycle bit and realigns the word.
    send_a(16'hFFFF, 7);
    clr_a    = 1'b1;
    ba.iEN   = 1'b1;
    ba.iDATA = 1'b1;
    tick();
    clr_a  = 1'b0;
    ba.iEN = 1'b0;
    chk("clr_valid", {31'h0, ba.oVALID}, 0);
    q_a.push_back('{d: 16'hA5A5, l: 1'b0});
    send_a(16'hA5A5, 16);
    drain_a();

    // Overflow: four held, fifth dropped, flag sticky until clear.
    clear_a();
    ba.iREADY = 1'b0;
    repeat (4) q_a.push_back('{d: 16'hFFFF, l: 1'b0});
    repeat (4) send_a(16'hFFFF, 16);
    chk("ovf_before", {31'h0, ovf_a}, 0);
    send_a(16'hFFFF, 16);
    chk("ovf_set", {31'h0, ovf_a}, 1);
    tick();
    chk("ovf_hold_valid", {31'h0, ba.oVALID}, 1);
    ba.iREADY = 1'b1;
    drain_a();
    repeat (3) tick();
    chk("ovf_no_extra", {31'h0, ba.oVALID}, 0);
    chk("ovf_sticky", {31'h0, ovf_a}, 1);
    clear_a();
    chk("ovf_cleared", {31'h0, ovf_a}, 0);

    // Full FIFO with a pop in the completing cycle: nothing dropped.
    ba.iREADY = 1'b0;
    q_a.push_back('{d: 16'h1111, l: 1'b0});
    q_a.push_back('{d: 16'h2222, l: 1'b0});
    q_a.push_back('{d: 16'h3333, l: 1'b0});
    q_a.push_back('{d: 16'h4444, l: 1'b0});
    q_a.push_back('{d: 16'h5A5A, l: 1'b0});
    send_a(16'h1111, 16);
    send_a(16'h2222, 16);
    send_a(16'h3333, 16);
    send_a(16'h4444, 16);
    send_a(16'h5A5A, 15);
    chk("stall_data", {16'h0, ba.oDATA}, 32'h1111);
    chk("stall_last", {31'h0, ba.oLAST}, 0);
    ba.iREADY = 1'b1;
    ba.iEN    = 1'b1;
    ba.iDATA  = 1'b0;
    tick();
    ba.iEN = 1'b0;
    chk("fp_ovf", {31'h0, ovf_a}, 0);
    drain_a();

    // Asynchronous reset mid-word with two words queued.
    clear_a();
    ba.iREADY = 1'b0;
    send_a(16'h00FF, 16);
    send_a(16'h0F0F, 16);
    send_a(16'hFFFF, 5);
    chk("pre_rst_valid", {31'h0, ba.oVALID}, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, ba.oVALID}, 0);
    chk("arst_data",  {16'h0, ba.oDATA}, 0);
    chk("arst_last",  {31'h0, ba.oLAST}, 0);
    chk("arst_ovf",   {31'h0, ovf_a}, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ba.iREADY = 1'b1;
    q_a.push_back('{d: 16'hFFFF, l: 1'b0});
    send_a(16'hFFFF, 16);
    drain_a();

    // Frame tail on the 20-bit-frame instance.
    q_b.push_back('{d: 16'hFFFF, l: 1'b0});
    q_b.push_back('{d: 16'h000F, l: 1'b1});
    send_b(16'hFFFF, 16);
    send_b(16'hFFFF, 3);
    chk("fd_early", {31'h0, fd_b}, 0);
    send_b(16'hFFFF, 1);
    chk("fd_pulse",  {31'h0, fd_b}, 1);
    chk("tail_data", {16'h0, bb.oDATA}, 32'h000F);
    chk("tail_last", {31'h0, bb.oLAST}, 1);
    tick();
    chk("fd_once", {31'h0, fd_b}, 0);
    q_b.push_back('{d: 16'h8001, l: 1'b0});
    send_b(16'h8001, 16);
    drain_b();

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
